// File: rtl/rng_pkg.sv
// Shared constants and types for the RNG output buffer slice.
// Holds default word/beat widths, FIFO depth, repetition-count cutoff,
// derived level width, overflow counter width and the serialiser phase type.
package rng_pkg;

  localparam int RNG_DATA_W     = 64;
  localparam int RNG_OUT_W      = 32;
  localparam int RNG_DEPTH      = 4;
  localparam int RNG_RCT_CUTOFF = 3;

  // Occupancy must be able to represent 0..DEPTH inclusive.
  localparam int RNG_LEVEL_W    = $clog2(RNG_DEPTH + 1);
  localparam int RNG_OVF_W      = 8;

  // Which half of the head word is currently presented on the output.
  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_t;

endpackage

// File: rtl/rng_sync_fifo.sv
// Synchronous FIFO with flush, occupancy level and full/empty flags.
// Ports: clk/rst, push + push_data, pop, flush (clears contents, wins over
// push/pop), head (show-ahead read data), level, full, empty.
module rng_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: an entry is only visible once level covers it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rng_output_buffer.sv
// RNG output buffer: repetition-count health test, word FIFO, 2-beat serialiser.
// Ports: in_valid/in_ready/in_data (64-bit words in), out_valid/out_ready/out_data
// (32-bit beats out, low half first), alarm (sticky), level, overflow_cnt.
module rng_output_buffer
  import rng_pkg::*;
#(
  parameter int DATA_W     = RNG_DATA_W,
  parameter int OUT_W      = RNG_OUT_W,   // DATA_W must equal 2*OUT_W
  parameter int DEPTH      = RNG_DEPTH,
  parameter int RCT_CUTOFF = RNG_RCT_CUTOFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  input  logic                       out_ready,
  output logic                       alarm,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [RNG_OVF_W-1:0]       overflow_cnt
);

  localparam int REP_W = $clog2(RCT_CUTOFF + 1);
  localparam logic [REP_W-1:0] CUTOFF = REP_W'(RCT_CUTOFF);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;

  logic [DATA_W-1:0] last_word;
  logic              last_vld;
  logic [REP_W-1:0]  rep_cnt;
  logic [REP_W-1:0]  rep_next;
  phase_t            phase;

  logic accept;
  logic trip;
  logic push;
  logic drop;
  logic beat;
  logic pop;

  // in_ready is gated by rst so it reads 0 throughout reset.
  assign in_ready = !full && !alarm && !rst;
  assign accept   = in_valid && in_ready;

  // Run length of the candidate word, counting it.
  always_comb begin
    rep_next = REP_ONE;
    if (last_vld && (in_data == last_word)) begin
      rep_next = rep_cnt + 1'b1;
    end
  end

  // The word that would complete the run is never stored.
  assign trip = accept && (rep_next == CUTOFF);
  assign push = accept && !trip;
  // Words refused because the FIFO is full are counted; post-alarm words are not.
  assign drop = in_valid && !in_ready && !alarm && !rst;

  assign out_valid = !empty && !alarm;
  assign beat      = out_valid && out_ready;
  assign pop       = beat && (phase == PH_HI);

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = (phase == PH_HI) ? head[DATA_W-1:OUT_W] : head[OUT_W-1:0];
    end
  end

  rng_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .flush     (trip),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm        <= 1'b0;
      phase        <= PH_LO;
      last_word    <= '0;
      last_vld     <= 1'b0;
      rep_cnt      <= '0;
      overflow_cnt <= '0;
    end else begin
      // A trip flushes the FIFO, so any half-sent word is abandoned too.
      if (trip) begin
        alarm <= 1'b1;
        phase <= PH_LO;
      end else if (beat) begin
        case (phase)
          PH_LO:   phase <= PH_HI;
          default: phase <= PH_LO;
        endcase
      end

      if (push) begin
        last_word <= in_data;
        last_vld  <= 1'b1;
        rep_cnt   <= rep_next;
      end

      if (drop && (overflow_cnt != '1)) begin
        overflow_cnt <= overflow_cnt + 1'b1;
      end
    end
  end

endmodule
